uart_rx: RTL

// - Serial-to-parallel UART receiver (8N1, LSB first) feeding cmd_parser's rxd_data/rxd_data_ready inputs.
// - Synchronises the asynchronous rx pin and oversamples each bit.
// - Majority-votes three samples around mid-bit.
// - Delivers each good byte with a one-cycle strobe. Flags framing errors and drops the byte.
//

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB-first, 3-sample majority vote at mid-bit.
// Define UART_RX_PARITY_EN for an 8E1 frame with an rxd_parity_err strobe.
module uart_rx #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxd_data,
  output logic       rxd_data_ready,
  output logic       rxd_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       rxd_parity_err,
`endif
  output logic       rxd_busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int HALF  = OVERSAMPLE / 2;

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
      $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t            state, state_nxt;
  logic              rx_p0, rx_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [OS_W-1:0]   tcnt;
  logic [2:0]        bit_idx;
  logic [1:0]        samp;
  logic [7:0]        shreg;
  logic              tick, wrap, samp_t, vote_t, vote, start_det;
  logic              ready_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic              par_bad, perr_nxt;
`endif

  // Stage p0/p1: two-flop synchroniser; only rx_s feeds decisions
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  assign start_det = (state == IDLE) && !rx_s;
  assign tick      = (div_cnt == DIV_W'(DIV - 1));
  assign wrap      = tick && (tcnt == OS_W'(OVERSAMPLE - 1));
  assign samp_t    = tick && ((tcnt == OS_W'(HALF - 1)) || (tcnt == OS_W'(HALF)));
  assign vote_t    = tick && (tcnt == OS_W'(HALF + 1));
  assign vote      = maj3(samp[1], samp[0], rx_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tcnt    <= '0;
      bit_idx <= '0;
    end else begin
      if (start_det || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;

      if (start_det)   tcnt <= '0;
      else if (wrap)   tcnt <= '0;
      else if (tick)   tcnt <= tcnt + 1'b1;

      if (state == START)              bit_idx <= '0;
      else if (state == DATA && wrap)  bit_idx <= bit_idx + 1'b1;
    end
  end

  // Sample shift and data shift register carry no reset
  always_ff @(posedge clk) begin
    if (samp_t) samp <= {samp[0], rx_s};
    if (state == DATA && vote_t) shreg <= {vote, shreg[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (state == PARITY && vote_t) par_bad <= ^{shreg, vote};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START: begin
        if (vote_t && vote) state_nxt = IDLE;
        else if (wrap)      state_nxt = DATA;
      end
      DATA: begin
        if (wrap && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (wrap) state_nxt = STOP;
`endif
      STOP:   if (vote_t) state_nxt = vote ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rxd_busy  = (state != IDLE);
    ferr_nxt  = (state == STOP) && vote_t && !vote;
`ifdef UART_RX_PARITY_EN
    ready_nxt = (state == STOP) && vote_t && vote && !par_bad;
    perr_nxt  = (state == STOP) && vote_t && vote && par_bad;
`else
    ready_nxt = (state == STOP) && vote_t && vote;
`endif
  end

  // Stage p2: registered strobes and held byte
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_data       <= '0;
      rxd_data_ready <= 1'b0;
      rxd_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rxd_parity_err <= 1'b0;
`endif
    end else begin
      if (ready_nxt) rxd_data <= shreg;
      rxd_data_ready <= ready_nxt;
      rxd_frame_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      rxd_parity_err <= perr_nxt;
`endif
    end
  end

endmodule
